// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default framing constants.
// Used by uart_tx_drain today and by uart_rx later.
package uart_pkg;

  localparam int DEF_DBIT    = 8;
  localparam int DEF_SB_TICK = 16;
  localparam int OVERSAMPLE  = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

endpackage

// File: rtl/baud_gen.sv
// Oversample tick generator: one-clk tick every BAUD_DIV clocks.
// clr restarts the count so a frame's first bit is a full bit long.
module baud_gen #(
  parameter int BAUD_DIV = 163
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     count <= '0;
    else if (clr || count == LAST) count <= '0;
    else                           count <= count + 1'b1;
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/uart_tx_drain.sv
// Pops bytes from a show-ahead FIFO and sends each as an 8N1-style UART frame.
// Define UART_TX_PARITY_EN to insert one parity bit (sense set by PAR_ODD).
import uart_pkg::*;

module uart_tx_drain #(
  parameter int DBIT     = DEF_DBIT,
  parameter int SB_TICK  = DEF_SB_TICK,
  parameter int BAUD_DIV = 163,
  parameter int PAR_ODD  = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tx_en,
  input  logic            fifo_empty,
  input  logic [DBIT-1:0] fifo_rdata,
  output logic            fifo_rd,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done_tick
);

  localparam int            NW          = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);
  localparam logic [4:0]    S_BIT_LAST  = 5'(OVERSAMPLE - 1);
  localparam logic [4:0]    S_STOP_LAST = 5'(SB_TICK - 1);

  if (PAR_ODD < 0 || PAR_ODD > 1) begin : g_par_odd_range
    $error("uart_tx_drain: PAR_ODD must be 0 or 1");
  end

  uart_state_t     state;
  logic [4:0]      s;
  logic [NW-1:0]   n;
  logic [DBIT-1:0] b;
  logic            tick;
`ifdef UART_TX_PARITY_EN
  logic            par;
`endif

  // Reset gating keeps the pop strobe quiet even though state already reads IDLE.
  assign fifo_rd = (state == IDLE) & tx_en & ~fifo_empty & ~reset;

  baud_gen #(.BAUD_DIV(BAUD_DIV)) u_baud (
    .clk   (clk),
    .reset (reset),
    .clr   (fifo_rd),
    .tick  (tick)
  );

  // tx is loaded with the value of the state being entered, so it is glitch-free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      tx           <= 1'b1;
      tx_busy      <= 1'b0;
      tx_done_tick <= 1'b0;
      s            <= '0;
      n            <= '0;
      b            <= '0;
`ifdef UART_TX_PARITY_EN
      par          <= 1'b0;
`endif
    end else begin
      tx_done_tick <= 1'b0;
      case (state)
        IDLE: begin
          if (fifo_rd) begin
            state   <= START;
            tx_busy <= 1'b1;
            tx      <= 1'b0;
            b       <= fifo_rdata;
            s       <= '0;
            n       <= '0;
`ifdef UART_TX_PARITY_EN
            par     <= (^fifo_rdata) ^ (PAR_ODD != 0);
`endif
          end
        end
        START: begin
          if (tick) begin
            if (s == S_BIT_LAST) begin
              state <= DATA;
              s     <= '0;
              n     <= '0;
              tx    <= b[0];
            end else begin
              s <= s + 5'd1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (s == S_BIT_LAST) begin
              s <= '0;
              b <= b >> 1;
              if (n == N_LAST) begin
`ifdef UART_TX_PARITY_EN
                state <= PARITY;
                tx    <= par;
`else
                state <= STOP;
                tx    <= 1'b1;
`endif
              end else begin
                n  <= n + 1'b1;
                tx <= b[1];
              end
            end else begin
              s <= s + 5'd1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (tick) begin
            if (s == S_BIT_LAST) begin
              state <= STOP;
              s     <= '0;
              tx    <= 1'b1;
            end else begin
              s <= s + 5'd1;
            end
          end
        end
`endif
        STOP: begin
          if (tick) begin
            if (s == S_STOP_LAST) begin
              state        <= IDLE;
              tx_busy      <= 1'b0;
              tx_done_tick <= 1'b1;
              s            <= '0;
              tx           <= 1'b1;
            end else begin
              s <= s + 5'd1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          tx_busy <= 1'b0;
          tx      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_drain.sv
// Scoreboard bench for uart_tx_drain: FIFO model feeds the DUT, a line monitor
// decodes each frame by cycle offset and checks it against the queued bytes.
module tb_uart_tx_drain;

  localparam int DBIT     = 8;
  localparam int SB_TICK  = 16;
  localparam int BAUD_DIV = 4;
  localparam int PAR_ODD  = 0;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int BIT_CLKS   = 16 * BAUD_DIV;
  localparam int HEAD_CLKS  = (1 + DBIT + P) * BIT_CLKS;
  localparam int FRAME_CLKS = HEAD_CLKS + SB_TICK * BAUD_DIV;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            tx_en = 1'b0;
  logic            fifo_empty;
  logic [DBIT-1:0] fifo_rdata;
  logic            fifo_rd, tx, tx_busy, tx_done_tick;

  logic [DBIT-1:0] fifo_mem [64];
  int              wr_ptr = 0, rd_ptr = 0;
  logic [DBIT-1:0] exp_mem [64];
  int              exp_wr = 0, exp_rd = 0;
  int              checks = 0, errors = 0;
  int              cyc = 0, started = 0, done = 0;
  int              start_cyc [64];
  int              done_cyc  [64];

  always #5 clk = ~clk;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_rdata = fifo_mem[rd_ptr % 64];

  always @(posedge clk) if (fifo_rd) rd_ptr <= rd_ptr + 1;

  uart_tx_drain #(
    .DBIT(DBIT), .SB_TICK(SB_TICK), .BAUD_DIV(BAUD_DIV), .PAR_ODD(PAR_ODD)
  ) dut (
    .clk(clk), .reset(reset), .tx_en(tx_en), .fifo_empty(fifo_empty),
    .fifo_rdata(fifo_rdata), .fifo_rd(fifo_rd), .tx(tx), .tx_busy(tx_busy),
    .tx_done_tick(tx_done_tick)
  );

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Line level expected at a given clk offset from the start edge.
  function automatic int exp_line(input logic [DBIT-1:0] d, input int off);
    int k;
    k = off / BIT_CLKS;
    if (off >= HEAD_CLKS) return 1;
    if (k == 0) return 0;
    if (k <= DBIT) return int'(d[k-1]);
    return int'(^d) ^ PAR_ODD;
  endfunction

  task automatic push(input logic [DBIT-1:0] d);
    fifo_mem[wr_ptr] = d;
    exp_mem[exp_wr]  = d;
    wr_ptr++;
    exp_wr++;
  endtask

  task automatic wait_done(input int target, input int budget);
    int k;
    k = 0;
    while (done < target && k < budget) begin @(negedge clk); k++; end
    chk("frames_done", done, target);
  endtask

  task automatic wait_started(input int target, input int budget);
    int k;
    k = 0;
    while (started < target && k < budget) begin @(negedge clk); k++; end
    chk("frames_started", started, target);
  endtask

  always @(negedge clk) begin
    if (fifo_rd) chk("pop_when_empty", int'(fifo_empty), 0);
    if (reset)   chk("rd_in_reset", int'(fifo_rd), 0);
  end

  initial begin : monitor
    logic            prev_tx;
    logic [DBIT-1:0] cur;
    int              off, m;
    bit              active;
    prev_tx = 1'b1; cur = '0; off = 0; active = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        active = 0;
      end else if (active) begin
        off++;
        if (off == FRAME_CLKS) begin
          chk("done_tick", int'(tx_done_tick), 1);
          chk("busy_after_frame", int'(tx_busy), 0);
          done_cyc[done] = cyc;
          done++;
          active = 0;
        end else begin
          m = off % BIT_CLKS;
          if (off == FRAME_CLKS - 1) chk("done_early", int'(tx_done_tick), 0);
          if (off == HEAD_CLKS / 2)  chk("busy_mid", int'(tx_busy), 1);
          if (m == 0 || m == BIT_CLKS / 2 || m == BIT_CLKS - 1)
            chk($sformatf("frame%0d_off%0d", started - 1, off), int'(tx), exp_line(cur, off));
        end
      end else if (prev_tx && !tx) begin
        if (exp_rd == exp_wr) begin
          chk("unexpected_frame", exp_wr - exp_rd, 1);
          cur = '0;
        end else begin
          cur = exp_mem[exp_rd];
          exp_rd++;
        end
        start_cyc[started] = cyc;
        started++;
        off = 0;
        active = 1;
        chk("busy_start", int'(tx_busy), 1);
      end else begin
        chk("done_idle", int'(tx_done_tick), 0);
      end
      prev_tx = reset ? 1'b1 : tx;
    end
  end

  initial begin : stim
    // Reset held with data waiting and tx_en high.
    reset = 1'b1;
    tx_en = 1'b1;
    push(8'hA5);
    repeat (8) begin
      @(negedge clk);
      chk("rst_tx", int'(tx), 1);
      chk("rst_busy", int'(tx_busy), 0);
      chk("rst_done", int'(tx_done_tick), 0);
    end
    reset = 1'b0;

    // Single frame 0xA5.
    wait_done(1, FRAME_CLKS + 20);
    chk("pops_single", rd_ptr, 1);

    // Back-to-back frames.
    @(negedge clk);
    push(8'h00); push(8'hFF); push(8'h3C);
    wait_done(4, 3 * FRAME_CLKS + 50);
    chk("pops_b2b", rd_ptr, 4);
    chk("gap_f2", start_cyc[2] - done_cyc[1], 1);
    chk("gap_f3", start_cyc[3] - done_cyc[2], 1);
    repeat (5) @(negedge clk);
    chk("idle_tx", int'(tx), 1);
    chk("idle_busy", int'(tx_busy), 0);

    // tx_en dropped mid-frame with words queued.
    push(8'h5A); push(8'hC3); push(8'h81);
    wait_started(5, 20);
    repeat (4 * BIT_CLKS + 10) @(negedge clk);
    tx_en = 1'b0;
    wait_done(5, FRAME_CLKS);
    repeat (3 * BIT_CLKS) @(negedge clk);
    chk("pops_while_disabled", rd_ptr, 5);
    chk("disabled_busy", int'(tx_busy), 0);
    chk("disabled_tx", int'(tx), 1);
    tx_en = 1'b1;
    #1 chk("rd_on_reenable", int'(fifo_rd), 1);
    @(negedge clk);
    chk("pops_after_reenable", rd_ptr, 6);
    wait_done(7, 2 * FRAME_CLKS + 20);

    // Reset in the middle of DATA.
    push(8'h96); push(8'h4B);
    wait_started(8, 20);
    repeat (3 * BIT_CLKS + 20) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_tx", int'(tx), 1);
    chk("abort_busy", int'(tx_busy), 0);
    chk("abort_rd", int'(fifo_rd), 0);
    repeat (5) @(negedge clk);
    chk("pops_in_reset", rd_ptr, 8);
    reset = 1'b0;
    wait_done(8, FRAME_CLKS + 20);

    // Random bytes with random tx_en pauses.
    for (int i = 0; i < 8; i++) begin
      push(DBIT'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 200)) @(negedge clk);
      if ($urandom_range(0, 2) == 0) begin
        tx_en = 1'b0;
        repeat ($urandom_range(1, 700)) @(negedge clk);
        tx_en = 1'b1;
      end
    end
    wait_done(16, 9 * FRAME_CLKS);

    repeat (4) @(negedge clk);
    chk("all_popped", rd_ptr, wr_ptr);
    chk("scoreboard_drained", exp_rd, exp_wr);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
